muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; reset asserted clears all state immediately.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 op_valid  in  1  execute stage issues an operation this cycle.
REQ-005 op  in  4  operation code (muldiv_op_t): NOP, MULT, MULTU, DIV, DIVU, MUL, MTHI, MTLO.
REQ-006 src_a / src_b  in  32 each  forwarded rs / rt operands.
REQ-007 flush  in  1  exception flush or execute-stage exception; aborts the in-flight operation.
REQ-008 busy  out  1  operation in progress; hi/lo not yet valid.
REQ-009 hi / lo  out  32 each  architectural HI/LO registers, driven directly from flops.

Function
REQ-010 Accept = op_valid & !busy & !flush & op in {MULT,MULTU,DIV,DIVU,MUL}; accept in cycle T latches operands and op.
REQ-011 busy SHALL be 1 in cycles T+1..T+N and 0 in cycle T+N+1; HI/LO SHALL update on the edge ending T+N and be readable whenever busy=0.
REQ-012 Division N=32: radix-2 restoring, one quotient bit per cycle, on absolute values for DIV; sign fixup at the final edge (quotient negative iff signs differ, remainder takes dividend sign).
REQ-013 Multiply (MULT/MULTU/MUL) N per REQ-025/026; HI=product[63:32], LO=product[31:0]; MUL SHALL also update HI and LO.
REQ-014 MTHI/MTLO with op_valid & !busy & !flush SHALL write src_a into HI/LO at that edge; busy SHALL stay 0.
REQ-015 Divide by zero SHALL give LO=32'hFFFFFFFF, HI=src_a, in both signed and unsigned modes, after the full N cycles.
REQ-016 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-017 flush while busy SHALL clear busy at the next edge and leave HI/LO unchanged.
REQ-018 flush in the same cycle as op_valid SHALL suppress the accept and any MTHI/MTLO write.
REQ-019 op_valid while busy SHALL be ignored (no restart, no HI/LO change).
REQ-020 Back-to-back: a new accept is legal in the first cycle with busy=0.
REQ-021 States: IDLE, MUL_RUN, DIV_RUN, with a cycle counter of 0..31.
REQ-022 Transitions: IDLE->RUN on accept; RUN->IDLE on count=N-1 or flush.

Reset
REQ-023 Reset asserted SHALL set hi=0, lo=0, busy=0, state=IDLE, counter=0 asynchronously.
REQ-024 Reset asserted mid-operation SHALL discard the operation; the first cycle after release SHALL be IDLE.

Configuration
REQ-025 MULDIV_FAST_MUL_EN defined: multiply uses a single-cycle 33x33 signed product registered at accept, so N=1 (busy only in T+1).
REQ-026 MULDIV_FAST_MUL_EN undefined: multiply is iterative shift-add on absolute values with sign fixup, N=32; division is unaffected.

Structure
REQ-027 Package muldiv_pkg SHALL hold muldiv_op_t, the state enum, MUL_LAT_FAST=1, MUL_LAT_ITER=32, and DIV_LAT=32.
REQ-028 The iterative divider SHALL be the sub-module muldiv_div_core (start, signed, a, b, abort -> done, quot, rem).

Verification
REQ-029 MULT src_a=32'hFFFFFFFE (-2), src_b=3 -> after N cycles hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, with busy high for exactly N cycles.
REQ-030 DIVU 100/7 -> busy high 32 cycles, then lo=14, hi=2; DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-031 DIV 5/0 -> lo=32'hFFFFFFFF, hi=5; DIV 32'h80000000/-1 -> lo=32'h80000000, hi=0.
REQ-032 MTLO 32'h1234 -> lo=32'h1234 next cycle with busy never asserted; start DIVU, then flush at T+10 -> busy=0 at T+11 and hi/lo unchanged.
REQ-033 Assert resetn=0 mid-DIV at T+5 -> hi=lo=0 and busy=0 immediately; MULTU issued while busy -> ignored and the original result is unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and latencies for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MUL   = 4'd5,
    OP_MTHI  = 4'd6,
    OP_MTLO  = 4'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } muldiv_state_t;

  localparam int MUL_LAT_FAST = 1;
  localparam int MUL_LAT_ITER = 32;
  localparam int DIV_LAT      = 32;

  // Magnitude of a 32-bit operand; only negated when treated as signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> multiply/divide unit connection.
interface muldiv_if;
  import muldiv_pkg::*;

  logic        op_valid;
  muldiv_op_t  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output op_valid, op, src_a, src_b, flush,
                  input  busy, hi, lo);
  modport slave  (input  op_valid, op, src_a, src_b, flush,
                  output busy, hi, lo);
endinterface

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed results fixed up
// on the final step; divide-by-zero yields quot=all-ones, rem=dividend.
module muldiv_div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        abort,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic        running_q;
  logic [4:0]  step_q;
  logic [31:0] q_q, r_q, d_q, a_orig_q;
  logic        neg_q_q, neg_r_q, by_zero_q;

  logic [32:0] trial, diff;
  logic        fits;
  logic [31:0] q_next, r_next;

  // Shift the next dividend bit into the partial remainder and try to subtract.
  assign trial  = {r_q, q_q[31]};
  assign diff   = trial - {1'b0, d_q};
  assign fits   = ~diff[32];
  assign r_next = fits ? diff[31:0] : trial[31:0];
  assign q_next = {q_q[30:0], fits};

  assign done = running_q && (step_q == 5'(DIV_LAT - 1));
  assign quot = by_zero_q ? 32'hFFFF_FFFF : (neg_q_q ? -q_next : q_next);
  assign rem  = by_zero_q ? a_orig_q      : (neg_r_q ? -r_next : r_next);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: datapath registers are reset too, so reset leaves no stale operands behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      running_q <= 1'b0;
      step_q    <= '0;
      q_q       <= '0;
      r_q       <= '0;
      d_q       <= '0;
      a_orig_q  <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      by_zero_q <= 1'b0;
    end else if (abort) begin
      running_q <= 1'b0;
      step_q    <= '0;
    end else if (start) begin
      running_q <= 1'b1;
      step_q    <= '0;
      q_q       <= abs32(a, signed_op);
      r_q       <= '0;
      d_q       <= abs32(b, signed_op);
      a_orig_q  <= a;
      neg_q_q   <= signed_op & (a[31] ^ b[31]);
      neg_r_q   <= signed_op & a[31];
      by_zero_q <= (b == 32'd0);
    end else if (running_q) begin
      q_q    <= q_next;
      r_q    <= r_next;
      step_q <= step_q + 5'd1;
      if (done) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit. Define MULDIV_FAST_MUL_EN for a single-cycle
// multiplier; otherwise multiply is iterative shift-add over 32 cycles.
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic      clk,
  input logic      resetn,
  muldiv_if.slave  bus
);

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = MUL_LAT_FAST;
`else
  localparam int MUL_LAT = MUL_LAT_ITER;
`endif
  localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LAST = 5'(DIV_LAT - 1);

  muldiv_state_t state_q, state_d;
  logic [4:0]    count_q, count_d;
  logic [31:0]   hi_q, lo_q;
  logic          busy, issue, is_mul_op, is_div_op, signed_op;
  logic          accept, mt_write, mul_wr, div_wr;
  logic [63:0]   mul_result;
  logic          div_done;
  logic [31:0]   div_quot, div_rem;

  assign busy      = (state_q != ST_IDLE);
  assign issue     = bus.op_valid & ~busy & ~bus.flush;
  assign is_mul_op = bus.op inside {OP_MULT, OP_MULTU, OP_MUL};
  assign is_div_op = bus.op inside {OP_DIV, OP_DIVU};
  assign signed_op = (bus.op != OP_MULTU) && (bus.op != OP_DIVU);
  assign accept    = issue & (is_mul_op | is_div_op);
  assign mt_write  = issue & ((bus.op == OP_MTHI) || (bus.op == OP_MTLO));
  // A flush on the final cycle still wins: the result is dropped.
  assign mul_wr    = (state_q == ST_MUL_RUN) && (count_q == MUL_LAST) && !bus.flush;
  assign div_wr    = (state_q == ST_DIV_RUN) && div_done && !bus.flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/count_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = is_div_op ? ST_DIV_RUN : ST_MUL_RUN;
          count_d = '0;
        end
      end
      ST_MUL_RUN, ST_DIV_RUN: begin
        if (bus.flush ||
            (state_q == ST_MUL_RUN && count_q == MUL_LAST) ||
            (state_q == ST_DIV_RUN && count_q == DIV_LAST)) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  // Operands sign/zero-extended from 33 bits; the low 64 product bits are exact.
  logic [63:0] fast_a, fast_b, fast_prod_q;
  assign fast_a = {{32{signed_op & bus.src_a[31]}}, bus.src_a};
  assign fast_b = {{32{signed_op & bus.src_b[31]}}, bus.src_b};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                fast_prod_q <= '0;
    else if (accept && is_mul_op) fast_prod_q <= fast_a * fast_b;
  end

  assign mul_result = fast_prod_q;
`else
  // Shift-add on magnitudes: multiplier sits in the low half and shifts out.
  logic [31:0] mcand_q;
  logic [63:0] prod_q, prod_next;
  logic [32:0] upper;
  logic        mul_neg_q;

  assign upper     = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign prod_next = {upper, prod_q[31:1]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_q   <= '0;
      prod_q    <= '0;
      mul_neg_q <= 1'b0;
    end else if (accept && is_mul_op) begin
      mcand_q   <= abs32(bus.src_a, signed_op);
      prod_q    <= {32'd0, abs32(bus.src_b, signed_op)};
      mul_neg_q <= signed_op & (bus.src_a[31] ^ bus.src_b[31]);
    end else if (state_q == ST_MUL_RUN) begin
      prod_q    <= prod_next;
    end
  end

  assign mul_result = mul_neg_q ? -prod_next : prod_next;
`endif

  muldiv_div_core u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (accept & is_div_op),
    .signed_op (signed_op),
    .a         (bus.src_a),
    .b         (bus.src_b),
    .abort     (bus.flush & (state_q == ST_DIV_RUN)),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mt_write) begin
      if (bus.op == OP_MTHI) hi_q <= bus.src_a;
      else                   lo_q <= bus.src_a;
    end else if (mul_wr) begin
      hi_q <= mul_result[63:32];
      lo_q <= mul_result[31:0];
    end else if (div_wr) begin
      hi_q <= div_rem;
      lo_q <= div_quot;
    end
  end

  assign bus.busy = busy;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_N = 1;
`else
  localparam int MUL_N = 32;
`endif
  localparam int DIV_N = 32;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_if bus();

  muldiv_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, truncating signed division.
  function automatic logic [63:0] ref_result(input muldiv_op_t op,
                                             input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint la, lb, q, r;
    sa = a; sb = b; la = sa; lb = sb;
    case (op)
      OP_MULT, OP_MUL: return 64'(la * lb);
      OP_MULTU:        return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = la / lb; r = la % lb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_latency(input muldiv_op_t op);
    return (op inside {OP_DIV, OP_DIVU}) ? DIV_N : MUL_N;
  endfunction

  // Called at a negedge: drives one op for one cycle, then counts busy cycles.
  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    bus.op_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = OP_NOP;
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    int c;
    run_op(OP_MTHI, h, 32'd0, c);
    run_op(OP_MTLO, l, 32'd0, c);
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_spec_vectors();
    muldiv_op_t  v_op [6] = '{OP_MULT, OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIVU};
    logic [31:0] v_a  [6] = '{32'hFFFF_FFFE, 32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'd9};
    logic [31:0] v_b  [6] = '{32'd3, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] v_hi [6] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd9};
    logic [31:0] v_lo [6] = '{32'hFFFF_FFFA, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    int c;
    for (int i = 0; i < 6; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], c);
      n_checks++; if (c != ref_latency(v_op[i])) begin n_fail++; $display("FAIL vec%0d_busy_cycles got=%0d want=%0d", i, c, ref_latency(v_op[i])); end
      n_checks++; if (bus.hi !== v_hi[i]) begin n_fail++; $display("FAIL vec%0d_hi got=%h want=%h", i, bus.hi, v_hi[i]); end
      n_checks++; if (bus.lo !== v_lo[i]) begin n_fail++; $display("FAIL vec%0d_lo got=%h want=%h", i, bus.lo, v_lo[i]); end
    end
  endtask

  task automatic test_mt();
    bus.op_valid = 1'b1; bus.op = OP_MTLO; bus.src_a = 32'h1234; bus.src_b = 32'd0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy_same got=%b want=0", bus.busy); end
    @(negedge clk);
    bus.op = OP_MTHI; bus.src_a = 32'hCAFE_0001;
    n_checks++; if (bus.lo !== 32'h1234) begin n_fail++; $display("FAIL mtlo_lo got=%h want=00001234", bus.lo); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got=%b want=0", bus.busy); end
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = OP_NOP;
    n_checks++; if (bus.hi !== 32'hCAFE_0001) begin n_fail++; $display("FAIL mthi_hi got=%h want=cafe0001", bus.hi); end
    n_checks++; if (bus.lo !== 32'h1234) begin n_fail++; $display("FAIL mthi_lo_kept got=%h want=00001234", bus.lo); end
  endtask

  task automatic test_flush();
    write_hilo(32'hAAAA_5555, 32'h5A5A_A5A5);
    // Flush coinciding with op_valid: neither a divide nor an MTHI may take effect.
    bus.op_valid = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd77; bus.src_b = 32'd5; bus.flush = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_same_busy got=%b want=0", bus.busy); end
    bus.op = OP_MTHI; bus.src_a = 32'h0BAD_0BAD;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = OP_NOP; bus.flush = 1'b0;
    n_checks++; if (bus.hi !== 32'hAAAA_5555) begin n_fail++; $display("FAIL flush_same_mthi got=%h want=aaaa5555", bus.hi); end
    // Flush mid-divide at T+10.
    bus.op_valid = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd7;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = OP_NOP;
    repeat (9) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL flush_t10_busy got=%b want=1", bus.busy); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_t11_busy got=%b want=0", bus.busy); end
    repeat (30) @(negedge clk);
    n_checks++; if (bus.hi !== 32'hAAAA_5555) begin n_fail++; $display("FAIL flush_hi got=%h want=aaaa5555", bus.hi); end
    n_checks++; if (bus.lo !== 32'h5A5A_A5A5) begin n_fail++; $display("FAIL flush_lo got=%h want=5a5aa5a5", bus.lo); end
  endtask

  task automatic test_busy_ignore();
    int c;
    bus.op_valid = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = OP_NOP;
    c = 0;
    while (bus.busy === 1'b1 && c < 100) begin
      c++;
      if (c == 3) begin bus.op_valid = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'hFFFF; bus.src_b = 32'hFFFF; end
      if (c == 4) begin bus.op = OP_MTLO; bus.src_a = 32'hDEAD; end
      if (c == 5) begin bus.op_valid = 1'b0; bus.op = OP_NOP; end
      @(negedge clk);
    end
    n_checks++; if (c != DIV_N) begin n_fail++; $display("FAIL ignore_busy_cycles got=%0d want=%0d", c, DIV_N); end
    n_checks++; if (bus.lo !== 32'd333) begin n_fail++; $display("FAIL ignore_lo got=%h want=%h", bus.lo, 32'd333); end
    n_checks++; if (bus.hi !== 32'd1) begin n_fail++; $display("FAIL ignore_hi got=%h want=1", bus.hi); end
  endtask

  task automatic test_reset_mid();
    write_hilo(32'h11, 32'h22);
    bus.op_valid = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd1000; bus.src_b = 32'hFFFF_FFFD;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = OP_NOP;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b want=0", bus.busy); end
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hi got=%h want=0", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid_lo got=%h want=0", bus.lo); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_busy got=%b want=0", bus.busy); end
    repeat (35) @(negedge clk);
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL rst_stale_lo got=%h want=0", bus.lo); end
  endtask

  // Ops issued in the very first idle cycle after the previous one completes.
  task automatic test_back_to_back();
    int c;
    logic [63:0] exp;
    muldiv_op_t  ops [5] = '{OP_MULTU, OP_DIV, OP_MUL, OP_DIVU, OP_MULT};
    logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'd10, 32'hFFFF_FFFF, 32'd16, 32'h8000_0000};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], c);
      exp = ref_result(ops[i], as[i], bs[i]);
      n_checks++; if (c != ref_latency(ops[i])) begin n_fail++; $display("FAIL b2b%0d_busy_cycles got=%0d want=%0d", i, c, ref_latency(ops[i])); end
      n_checks++; if ({bus.hi, bus.lo} !== exp) begin n_fail++; $display("FAIL b2b%0d_hilo got=%h want=%h", i, {bus.hi, bus.lo}, exp); end
    end
  endtask

  task automatic test_random();
    int c;
    muldiv_op_t op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: op = OP_MULT;
        1: op = OP_MULTU;
        2: op = OP_DIV;
        3: op = OP_DIVU;
        default: op = OP_MUL;
      endcase
      a = $urandom(); b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 255);
        default: ;
      endcase
      run_op(op, a, b, c);
      exp = ref_result(op, a, b);
      n_checks++; if (c != ref_latency(op)) begin n_fail++; $display("FAIL rand%0d_busy_cycles op=%0d got=%0d want=%0d", i, op, c, ref_latency(op)); end
      n_checks++; if ({bus.hi, bus.lo} !== exp) begin n_fail++; $display("FAIL rand%0d_hilo op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, {bus.hi, bus.lo}, exp); end
    end
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.op = OP_NOP; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    test_reset();
    test_spec_vectors();
    test_mt();
    test_flush();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
